// File: rtl/alu_pkg.sv
// Shared definitions for the iterative execute unit and the ALU control decoder.
// Holds the alu_ctrl code points, the execute FSM states and width defaults.
package alu_pkg;

    localparam int ALU_XLEN    = 32;
    localparam int ALU_SHAMT_W = 5;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_LUI  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/iter_alu_if.sv
// Operand/result handshake bundle between the ID/EX operand stage and the execute unit.
// slave = execute unit side, master = producer/consumer side.
interface iter_alu_if #(
    parameter int XLEN = alu_pkg::ALU_XLEN
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic            unsigned_signal;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            lt;
    logic            illegal;

    modport slave (
        input  in_valid, alu_ctrl, unsigned_signal, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, lt, illegal
    );

    modport master (
        output in_valid, alu_ctrl, unsigned_signal, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, lt, illegal
    );
endinterface

// File: rtl/iter_shifter.sv
// One-bit-per-cycle shifter: loads operand and count on start, then shifts until the count expires.
// data_o is the value after the current step, so the owner can capture it on the done cycle.
module iter_shifter
    import alu_pkg::*;
#(
    parameter int XLEN    = ALU_XLEN,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [3:0]         ctrl_i,
    input  logic [XLEN-1:0]    data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [XLEN-1:0]    data_o
);

    logic [XLEN-1:0]    shreg_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               left_q;
    logic               arith_q;
    logic [XLEN-1:0]    step;

    // Right shifts fill with the sign bit only for the arithmetic variant.
    assign step   = left_q ? {shreg_q[XLEN-2:0], 1'b0}
                           : {arith_q & shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
    assign busy_o = (cnt_q != '0);
    assign done_o = (cnt_q == SHAMT_W'(1));
    assign data_o = step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else if (start_i) begin
            shreg_q <= data_i;
            cnt_q   <= shamt_i;
            left_q  <= (ctrl_i == ALU_SLL);
            arith_q <= (ctrl_i == ALU_SRA);
        end else if (busy_o) begin
            shreg_q <= step;
            cnt_q   <= cnt_q - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Execute unit: single-cycle logic/arith ops, iterative shifts, registered result and flags.
// state | meaning:  IDLE accepting an op | SHIFT shifter running | DONE result held for consumer
module iter_alu
    import alu_pkg::*;
#(
    parameter int XLEN    = ALU_XLEN,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    iter_alu_if.slave  bus
);

    state_e             state_q, state_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               zero_q, zero_d;
    logic               lt_q, lt_d;
    logic               illegal_q, illegal_d;
    logic [XLEN-1:0]    alu_res;
    logic [XLEN-1:0]    sh_next;
    logic [SHAMT_W-1:0] shamt;
    logic               legal;
    logic               lt_acc;
    logic               lt_s;
    logic               lt_u;
    logic               sh_start;
    logic               sh_busy;
    logic               sh_done;

    assign shamt = bus.op_b[SHAMT_W-1:0];
    assign lt_s  = $signed(bus.op_a) < $signed(bus.op_b);
    assign lt_u  = bus.op_a < bus.op_b;
    assign lt_acc = bus.unsigned_signal ? lt_u : lt_s;

    // Shift codes land here only with shamt == 0, where the result is op_a unchanged.
    always_comb begin
        alu_res = '0;
        legal   = 1'b1;
        case (bus.alu_ctrl)
            ALU_AND:  alu_res = bus.op_a & bus.op_b;
            ALU_OR:   alu_res = bus.op_a | bus.op_b;
            ALU_ADD:  alu_res = bus.op_a + bus.op_b;
            ALU_SUB:  alu_res = bus.op_a - bus.op_b;
            ALU_XOR:  alu_res = bus.op_a ^ bus.op_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  alu_res = bus.op_a;
            ALU_LUI:  alu_res = bus.op_b;
            default:  legal   = 1'b0;
        endcase
    end

    iter_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (sh_start),
        .ctrl_i  (bus.alu_ctrl),
        .data_i  (bus.op_a),
        .shamt_i (shamt),
        .busy_o  (sh_busy),
        .done_o  (sh_done),
        .data_o  (sh_next)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        lt_d      = lt_q;
        illegal_d = illegal_q;
        sh_start  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    lt_d      = lt_acc;
                    illegal_d = !legal;
                    if (is_shift(bus.alu_ctrl) && (shamt != '0)) begin
                        sh_start = 1'b1;
                        state_d  = SHIFT;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                if (sh_busy && sh_done) begin
                    result_d = sh_next;
                    zero_d   = (sh_next == '0);
                    state_d  = DONE;
                end else if (!sh_busy) begin
                    state_d  = IDLE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            lt_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            lt_q      <= lt_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.lt        = lt_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_iter_alu.sv
// Bench for iter_alu: directed vector table, handshake corner sequences, and random ops
// checked against an arithmetic reference model.
module tb_iter_alu;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    iter_alu_if #(.XLEN(32)) bus ();

    iter_alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic        uns;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_lt;
        logic        exp_ill;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        lt;
        logic        ill;
        int          lat;
    } ref_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic ref_t model(input logic [3:0] c, input logic u,
                                   input logic [31:0] a, input logic [31:0] b);
        ref_t r;
        int   sh;
        sh     = int'(b % 32);
        r.ill  = 1'b0;
        r.lat  = 1;
        r.res  = 32'd0;
        r.lt   = u ? (a < b) : ($signed(a) < $signed(b));
        case (c)
            4'b0000: r.res = a & b;
            4'b0001: r.res = a | b;
            4'b0010: r.res = a + b;
            4'b0110: r.res = a - b;
            4'b0111: r.res = a ^ b;
            4'b0100: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0101: r.res = (a < b) ? 32'd1 : 32'd0;
            4'b0011: begin r.res = a << sh;            r.lat = sh + 1; end
            4'b1000: begin r.res = a >> sh;            r.lat = sh + 1; end
            4'b1010: begin r.res = $signed(a) >>> sh;  r.lat = sh + 1; end
            4'b1011: r.res = b;
            default: r.ill = 1'b1;
        endcase
        r.zero = (r.res == 32'd0);
        return r;
    endfunction

    // Call with the DUT idle, right after a clock edge. Leaves it idle again.
    task automatic run_op(input logic [3:0] c, input logic u, input logic [31:0] a,
                          input logic [31:0] b, output ref_t got, output logic busy_ok);
        bus.alu_ctrl        = c;
        bus.unsigned_signal = u;
        bus.op_a            = a;
        bus.op_b            = b;
        bus.in_valid        = 1'b1;
        bus.out_ready       = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        got.lat = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && got.lat < 100) begin
            if (bus.in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            got.lat++;
        end
        if (bus.in_ready) busy_ok = 1'b0;
        got.res  = bus.result;
        got.zero = bus.zero;
        got.lt   = bus.lt;
        got.ill  = bus.illegal;
        if (!bus.out_valid) got.lat = -1;
        @(posedge clk); #1;
    endtask

    task automatic compare(input string tag, input ref_t got, input ref_t exp, input logic busy_ok);
        check({tag, " result"},  got.res, exp.res);
        check({tag, " zero"},    32'(got.zero), 32'(exp.zero));
        check({tag, " lt"},      32'(got.lt), 32'(exp.lt));
        check({tag, " illegal"}, 32'(got.ill), 32'(exp.ill));
        check({tag, " latency"}, 32'(got.lat), 32'(exp.lat));
        check({tag, " in_ready low while busy"}, 32'(busy_ok), 32'd1);
    endtask

    initial begin
        ref_t        got, exp;
        logic        ok;
        logic [31:0] held;

        n_checks = 0;
        n_fail   = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.alu_ctrl = 4'd0;
        bus.unsigned_signal = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;

        vecs[0]  = '{ALU_ADD,  1'b0, 32'd5,        32'd7,        32'd12,       1'b0, 1'b1, 1'b0, 1};
        vecs[1]  = '{ALU_SUB,  1'b0, 32'd3,        32'd3,        32'd0,        1'b1, 1'b0, 1'b0, 1};
        vecs[2]  = '{ALU_SUB,  1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1};
        vecs[3]  = '{ALU_SUB,  1'b1, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1};
        vecs[4]  = '{ALU_SLTU, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1'b0, 1};
        vecs[5]  = '{ALU_SLT,  1'b0, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b1, 1'b0, 1};
        vecs[6]  = '{ALU_SRA,  1'b0, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b1, 1'b0, 5};
        vecs[7]  = '{ALU_SLL,  1'b0, 32'd1,        32'd31,       32'h80000000, 1'b0, 1'b1, 1'b0, 32};
        vecs[8]  = '{ALU_SRL,  1'b1, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1};
        vecs[9]  = '{ALU_LUI,  1'b0, 32'd0,        32'h12345000, 32'h12345000, 1'b0, 1'b1, 1'b0, 1};
        vecs[10] = '{4'b1111,  1'b0, 32'd1,        32'd2,        32'd0,        1'b1, 1'b1, 1'b1, 1};
        vecs[11] = '{ALU_AND,  1'b0, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0, 1'b0, 1'b0, 1};
        vecs[12] = '{ALU_SRL,  1'b1, 32'h80000000, 32'd33,       32'h40000000, 1'b0, 1'b0, 1'b0, 2};
        vecs[13] = '{ALU_XOR,  1'b0, 32'h000000FF, 32'h0000000F, 32'h000000F0, 1'b0, 1'b0, 1'b0, 1};
        vecs[14] = '{ALU_OR,   1'b0, 32'd0,        32'd0,        32'd0,        1'b1, 1'b0, 1'b0, 1};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        check("reset in_ready",  32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result",    bus.result, 32'd0);
        check("reset zero",      32'(bus.zero), 32'd0);
        check("reset lt",        32'(bus.lt), 32'd0);
        check("reset illegal",   32'(bus.illegal), 32'd0);

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].ctrl, vecs[i].uns, vecs[i].a, vecs[i].b, got, ok);
            exp.res  = vecs[i].exp_res;
            exp.zero = vecs[i].exp_zero;
            exp.lt   = vecs[i].exp_lt;
            exp.ill  = vecs[i].exp_ill;
            exp.lat  = vecs[i].exp_lat;
            compare($sformatf("vec%0d", i), got, exp, ok);
        end

        // Backpressure: LUI completes while out_ready is low; in_valid during DONE must be ignored.
        bus.alu_ctrl = ALU_LUI;
        bus.unsigned_signal = 1'b0;
        bus.op_a = 32'd0;
        bus.op_b = 32'h12345000;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.alu_ctrl = ALU_ADD;
        bus.op_a = 32'd1;
        bus.op_b = 32'd1;
        check("bp out_valid after accept", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("bp out_valid held", 32'(bus.out_valid), 32'd1);
            check("bp result held",    bus.result, 32'h12345000);
            check("bp zero held",      32'(bus.zero), 32'd0);
            check("bp in_ready low",   32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp out_valid drops", 32'(bus.out_valid), 32'd0);
        check("bp in_ready back",   32'(bus.in_ready), 32'd1);
        check("bp held op not consumed", bus.result, 32'h12345000);

        // Reset in the middle of a long shift discards it.
        bus.alu_ctrl = ALU_SLL;
        bus.op_a = 32'd1;
        bus.op_b = 32'd20;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midreset out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset result",    bus.result, 32'd0);
        check("midreset in_ready",  32'(bus.in_ready), 32'd1);
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.out_valid) break;
        end
        check("midreset no stale result", 32'(bus.out_valid), 32'd0);
        run_op(ALU_ADD, 1'b0, 32'd100, 32'd23, got, ok);
        compare("post-reset add", got, model(ALU_ADD, 1'b0, 32'd100, 32'd23), ok);

        for (int n = 0; n < 200; n++) begin
            logic [3:0]  c;
            logic        u;
            logic [31:0] a, b;
            c = 4'($urandom_range(0, 15));
            u = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (n % 3 == 0) b = 32'($urandom_range(0, 40));
            if (n % 7 == 0) b = a;
            run_op(c, u, a, b, got, ok);
            held = 32'(n);
            compare($sformatf("rand%0d ctrl=%0h", held, c), got, model(c, u, a, b), ok);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
